// File: rtl/mem_stage_ctrl.sv
// M-stage data-memory sequencer: issues one req/ack access per load/store,
// stalls the upstream pipeline until it completes, and flags misalign/timeout.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        memWriteM,
    input  logic        memToRegM,
    input  logic [1:0]  storeM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stallM,
    output logic [31:0] readDataM,
    output logic        readValidM,
    output logic        busErr
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, nextState;
    logic [CNT_W-1:0] count;
    logic             acc;
    logic             misaligned;
    logic             startAcc;
    logic             ackHit;
    logic             timeoutHit;
    logic [3:0]       beCalc;
    logic [31:0]      wdataCalc;

    assign acc = memWriteM | memToRegM;

    always_comb begin
        misaligned = 1'b0;
        beCalc     = 4'b1111;
        wdataCalc  = writeDataM;
        case (storeM)
            2'b01: begin
                misaligned = aluOutM[0];
                wdataCalc  = {2{writeDataM[15:0]}};
                if (memWriteM) beCalc = aluOutM[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                wdataCalc = {4{writeDataM[7:0]}};
                if (memWriteM) beCalc = 4'b0001 << aluOutM[1:0];
            end
            default: misaligned = (aluOutM[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= nextState;
    end

    // stallM must rise in the same cycle the access is detected, so it is decoded here
    always_comb begin
        nextState  = state;
        stallM     = 1'b0;
        startAcc   = 1'b0;
        ackHit     = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (acc && !misaligned) begin
                    startAcc  = 1'b1;
                    stallM    = 1'b1;
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                stallM = 1'b1;
                if (mem_ack) begin
                    ackHit    = 1'b1;
                    nextState = DONE;
                end else if (count == CNT_LAST) begin
                    timeoutHit = 1'b1;
                    nextState  = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (!RST) stallM = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            count      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= 4'b0000;
            readDataM  <= '0;
            readValidM <= 1'b0;
            busErr     <= 1'b0;
        end else begin
            readValidM <= 1'b0;
            busErr     <= 1'b0;
            if (state == IDLE && acc && misaligned) busErr <= 1'b1;
            if (startAcc) begin
                mem_req   <= 1'b1;
                mem_we    <= memWriteM;
                mem_addr  <= {aluOutM[31:2], 2'b00};
                mem_be    <= beCalc;
                mem_wdata <= wdataCalc;
                count     <= '0;
            end
            // Request fields stay frozen after completion; only mem_req drops
            if (ackHit) begin
                mem_req <= 1'b0;
                if (!mem_we) begin
                    readDataM  <= mem_rdata;
                    readValidM <= 1'b1;
                end
            end else if (timeoutHit) begin
                mem_req   <= 1'b0;
                busErr    <= 1'b1;
                readDataM <= '0;
            end else if (state == ACCESS) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed transactions checked every cycle against
// a timeline model of each access, plus literal per-transaction expectations.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        memWriteM = 1'b0;
    logic        memToRegM = 1'b0;
    logic [1:0]  storeM = 2'b00;
    logic [31:0] aluOutM = '0;
    logic [31:0] writeDataM = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stallM;
    logic [31:0] readDataM;
    logic        readValidM;
    logic        busErr;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .memWriteM(memWriteM), .memToRegM(memToRegM), .storeM(storeM),
        .aluOutM(aluOutM), .writeDataM(writeDataM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stallM(stallM), .readDataM(readDataM),
        .readValidM(readValidM), .busErr(busErr)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    // Transaction descriptor shared by the driver and the compare process
    bit          active = 1'b0;
    int          rel = 0;
    bit          tWr, tLoad, tMis, tAcked;
    int          tN, tRstAt;
    logic [1:0]  tSt;
    logic [31:0] tAddr, tWd, tRdata;
    logic [31:0] modelRead = '0;
    int          stallCnt, reqCnt;
    logic [3:0]  lastBe;
    logic [31:0] lastWd;
    bit          eStall, eReq, eVal, eErr;

    function automatic int sizeBytes(input logic [1:0] st);
        if (st == 2'b10) return 1;
        if (st == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit modelMis(input logic [1:0] st, input logic [31:0] addr);
        return (int'(addr[1:0]) % sizeBytes(st)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input bit isStore, input logic [1:0] st,
                                           input logic [31:0] addr);
        int n;
        if (!isStore) return 4'hF;
        n = sizeBytes(st);
        return 4'(((1 << n) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] modelWd(input logic [1:0] st, input logic [31:0] wd);
        logic [31:0] res;
        int n;
        n = sizeBytes(st);
        for (int i = 0; i < 4; i++) res[8*i +: 8] = wd[8*(i % n) +: 8];
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                      name, actual, expected, rel);
    endtask

    always @(negedge CLK) begin
        if (active) begin
            if (tRstAt >= 0 && rel > tRstAt) begin
                eStall = 0; eReq = 0; eVal = 0; eErr = 0;
                modelRead = '0;
                checkOutput("rst mem_addr", mem_addr, 32'h0);
                checkOutput("rst mem_we", 32'(mem_we), 32'h0);
                checkOutput("rst mem_be", 32'(mem_be), 32'h0);
                checkOutput("rst mem_wdata", mem_wdata, 32'h0);
            end else if (tMis) begin
                eStall = 0; eReq = 0; eVal = 0;
                eErr = (rel == 1);
            end else begin
                eStall = (rel <= tN) && (rel != tRstAt);
                eReq   = (rel >= 1) && (rel <= tN);
                eVal   = (rel == tN + 1) && tAcked && tLoad;
                eErr   = (rel == tN + 1) && !tAcked;
                if (rel == tN + 1) begin
                    if (!tAcked)    modelRead = '0;
                    else if (tLoad) modelRead = tRdata;
                end
            end
            checkOutput("stallM", 32'(stallM), 32'(eStall));
            checkOutput("mem_req", 32'(mem_req), 32'(eReq));
            checkOutput("readValidM", 32'(readValidM), 32'(eVal));
            checkOutput("busErr", 32'(busErr), 32'(eErr));
            checkOutput("readDataM", readDataM, modelRead);
            if (eReq) begin
                checkOutput("mem_addr", mem_addr, {tAddr[31:2], 2'b00});
                checkOutput("mem_we", 32'(mem_we), 32'(tWr));
                checkOutput("mem_be", 32'(mem_be), 32'(modelBe(tWr, tSt, tAddr)));
                checkOutput("mem_wdata", mem_wdata, modelWd(tSt, tWd));
            end
            if (stallM) stallCnt++;
            if (mem_req) begin
                reqCnt++;
                lastBe = mem_be;
                lastWd = mem_wdata;
            end
        end
    end

    // ackAt: ACCESS cycle number carrying mem_ack (-1 = never); rstAt: cycle with RST low (-1 = none)
    task automatic applyStimulus(input string name, input logic wr, input logic rd,
                                 input logic [1:0] st, input logic [31:0] addr,
                                 input logic [31:0] wd, input int ackAt,
                                 input logic [31:0] rdata, input int rstAt,
                                 input int stallLit, input int reqLit,
                                 input logic [3:0] beLit, input logic [31:0] wdLit);
        int len;
        bit present;
        tWr = wr; tLoad = rd && !wr; tSt = st; tAddr = addr; tWd = wd;
        tRdata = rdata; tRstAt = rstAt;
        tMis = modelMis(st, addr);
        tAcked = (ackAt >= 1) && (ackAt <= TIMEOUT);
        tN = tAcked ? ackAt : TIMEOUT;
        len = tMis ? 3 : ((rstAt >= 0) ? rstAt + 5 : tN + 3);
        stallCnt = 0;
        reqCnt = 0;
        for (int r = 0; r < len; r++) begin
            @(posedge CLK); #1;
            present = tMis ? (r == 0) : (r <= tN + 1);
            if (rstAt >= 0 && r >= rstAt) present = 0;
            RST = (r == rstAt) ? 1'b0 : 1'b1;
            memWriteM = present & wr;
            memToRegM = present & rd;
            storeM = st;
            aluOutM = addr;
            writeDataM = wd;
            mem_ack = (r == ackAt);
            mem_rdata = (r == ackAt) ? rdata : 32'hBAD0_BAD0;
            rel = r;
            active = 1'b1;
        end
        @(posedge CLK); #1;
        active = 1'b0;
        mem_ack = 1'b0;
        memWriteM = 1'b0;
        memToRegM = 1'b0;
        checkOutput({name, " stall cycles"}, 32'(stallCnt), 32'(stallLit));
        checkOutput({name, " req cycles"}, 32'(reqCnt), 32'(reqLit));
        if (reqLit > 0) begin
            checkOutput({name, " be"}, 32'(lastBe), 32'(beLit));
            checkOutput({name, " wdata"}, lastWd, wdLit);
            checkOutput({name, " model be"}, 32'(modelBe(wr, st, addr)), 32'(beLit));
            checkOutput({name, " model wdata"}, modelWd(st, wd), wdLit);
        end
    endtask

    initial begin
        $display("[TB] starting mem_stage_ctrl bench");
        RST = 1'b0;
        memToRegM = 1'b1;
        aluOutM = 32'h0000_0100;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset stallM", 32'(stallM), 32'h0);
        checkOutput("reset mem_req", 32'(mem_req), 32'h0);
        checkOutput("reset mem_we", 32'(mem_we), 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        checkOutput("reset mem_be", 32'(mem_be), 32'h0);
        checkOutput("reset readDataM", readDataM, 32'h0);
        checkOutput("reset readValidM", 32'(readValidM), 32'h0);
        checkOutput("reset busErr", 32'(busErr), 32'h0);
        memToRegM = 1'b0;
        aluOutM = '0;
        RST = 1'b1;
        @(posedge CLK); #1;

        applyStimulus("word load", 1'b0, 1'b1, 2'b00, 32'h0000_0104, 32'h1122_3344,
                      2, 32'hDEAD_BEEF, -1, 3, 2, 4'b1111, 32'h1122_3344);
        applyStimulus("byte store", 1'b1, 1'b0, 2'b10, 32'h0000_0203, 32'h0000_00A5,
                      1, 32'h0, -1, 2, 1, 4'b1000, 32'hA5A5_A5A5);
        applyStimulus("half misaligned", 1'b1, 1'b0, 2'b01, 32'h0000_0301, 32'h0000_BEEF,
                      -1, 32'h0, -1, 0, 0, 4'b0000, 32'h0);
        applyStimulus("load timeout", 1'b0, 1'b1, 2'b00, 32'h0000_0400, 32'h0,
                      -1, 32'h0, -1, 16, 15, 4'b1111, 32'h0);
        applyStimulus("both half", 1'b1, 1'b1, 2'b01, 32'h0000_0502, 32'h0000_1234,
                      3, 32'h5555_AAAA, -1, 4, 3, 4'b1100, 32'h1234_1234);
        applyStimulus("byte load", 1'b0, 1'b1, 2'b10, 32'h0000_1001, 32'h0000_0077,
                      1, 32'h0000_00AB, -1, 2, 1, 4'b1111, 32'h7777_7777);
        applyStimulus("word misaligned", 1'b0, 1'b1, 2'b00, 32'h0000_0606, 32'h0,
                      -1, 32'h0, -1, 0, 0, 4'b0000, 32'h0);
        applyStimulus("reset mid-access", 1'b0, 1'b1, 2'b00, 32'h0000_0040, 32'h0,
                      4, 32'hCAFE_F00D, 2, 2, 2, 4'b1111, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the data-memory access for the instruction held in the EX/MEM pipeline register (M stage) of the pipelined MIPS core.
- Drives a req/ack data-memory port and generates byte enables and lane-replicated write data from storeM.
- Holds stallM high to freeze the upstream pipeline, including the EX/MEM register, until the access completes.
- Flags misaligned accesses and memory timeouts on busErr.

Parameters:
- TIMEOUT, 15: max ACCESS cycles without mem_ack before abort (1..255).
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- memWriteM  in  1  store in M stage.
- memToRegM  in  1  load in M stage.
- storeM  in  2  access size: 00 word, 01 half, 10 byte, 11 word.
- aluOutM  in  32  effective address.
- writeDataM  in  32  store data, right-aligned.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  word address, {aluOutM[31:2],2'b00}, registered.
- mem_wdata  out  32  lane-replicated store data, registered.
- mem_be  out  4  byte enables, registered.
- mem_ack  in  1  single-cycle completion from memory.
- mem_rdata  in  32  read data, valid with mem_ack.
- stallM  out  1  freeze pipeline; combinational from state and inputs.
- readDataM  out  32  captured load word, raw with no extension.
- readValidM  out  1  load data valid, one-cycle pulse.
- busErr  out  1  misalign/timeout, one-cycle pulse.

Behaviour:
- Clocking and reset: one clock, CLK; reset RST is synchronous and active-low.
- Reset values: state IDLE, counter 0, mem_req/mem_we/readValidM/busErr 0, mem_addr/mem_wdata/readDataM 0, mem_be 4'b0000. stallM is forced 0 while RST=0.
- Access present: acc = memWriteM | memToRegM. If both are set, treat it as a store.
- Misaligned: word with aluOutM[1:0]!=0, or half with aluOutM[0]=1.
- Byte enables:
  - word: 1111.
  - half: aluOutM[1] ? 1100 : 0011.
  - byte: 0001 << aluOutM[1:0].
  - loads always use 1111.
- Write data: byte replicates writeDataM[7:0] four times; half replicates [15:0] twice; word passes through.
- FSM IDLE:
  - If acc and aligned: stallM=1 (combinational, same cycle). Register mem_req=1, mem_we, mem_addr, mem_be, mem_wdata; go ACCESS; counter=0.
  - If acc and misaligned: no request, stallM=0, busErr=1 next cycle, stay IDLE.
  - mem_ack is ignored in this state.
- FSM ACCESS:
  - stallM=1. mem_req and all request fields held stable.
  - On mem_ack: for loads, readDataM<=mem_rdata and readValidM<=1. mem_req<=0; go DONE.
  - Else if counter==TIMEOUT-1: mem_req<=0, busErr<=1, readDataM<=0; go DONE.
  - Else counter++.
- FSM DONE:
  - stallM=0, so the EX/MEM register advances at the end of this cycle. readValidM/busErr pulses are visible here.
  - Go IDLE unconditionally; never re-triggers on the same instruction. mem_ack is ignored.
- Latency: with ack in the first ACCESS cycle, stall lasts 2 cycles (IDLE detect + ACCESS). Back-to-back accesses complete every 3 cycles.
- Pulses: readValidM and busErr are each high exactly one cycle and never both for the same access.
- Reset mid-access: the next edge forces IDLE and mem_req=0. A late mem_ack is ignored.

Test Plan:
- Word load, addr 0x0000_0104, ack after 2 ACCESS cycles, rdata 0xDEAD_BEEF:
  - mem_req high 2 cycles, mem_addr 0x104, be 1111, we 0.
  - stallM high 3 cycles.
  - readDataM=0xDEADBEEF and readValidM pulse in DONE.
- Byte store storeM=10, addr 0x...03, writeDataM 0x0000_00A5, ack immediate:
  - be 1000, wdata 0xA5A5_A5A5, we 1.
  - stallM high 2 cycles, no readValidM.
- Half store storeM=01 at addr 0x...01 (misaligned) -> mem_req never asserted, stallM 0, busErr one-cycle pulse next cycle.
- Load with no ack, TIMEOUT=15 -> mem_req high exactly 15 cycles, then busErr pulse, readDataM=0, readValidM 0, FSM returns IDLE.
- memWriteM=memToRegM=1, half at addr 0x...02, data 0x1234 -> we 1, be 1100, wdata 0x1234_1234.
- RST low in 2nd ACCESS cycle, ack arrives after RST returns high -> all outputs at reset values, mem_req 0 after the edge, ack ignored, no readValidM/busErr.
